// File: rtl/synth_pkg.sv
// Shared synthesiser constants and the scheduler state type.
// Imported by the voice mixer and any future ROM arbiters.
package synth_pkg;

    localparam int NUM_VOICES = 24;
    localparam int PHASE_W    = 32;
    localparam int SAMPLE_W   = 8;
    localparam int OUT_W      = SAMPLE_W + $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that carries per-lookup tags
// alongside the ROM read latency.
module tag_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tag,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= tag;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/voice_mix_scheduler.sv
// Shares one waveform ROM across all voices: snapshot on tick,
// one lookup per cycle, sum gated samples into one mixed sample.
module voice_mix_scheduler #(
    parameter int NUM_VOICES  = synth_pkg::NUM_VOICES,
    parameter int PHASE_W     = synth_pkg::PHASE_W,
    parameter int ADDR_W      = 8,
    parameter int SAMPLE_W    = synth_pkg::SAMPLE_W,
    parameter int ROM_LATENCY = 2,
    localparam int OUT_W      = SAMPLE_W + $clog2(NUM_VOICES),
    localparam int CNT_W      = $clog2(NUM_VOICES + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          sample_tick_in,
    input  logic [NUM_VOICES-1:0]         gate_in,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_value_in,
    output logic [ADDR_W-1:0]             rom_addr_out,
    input  logic [SAMPLE_W-1:0]           rom_data_in,
    output logic signed [OUT_W-1:0]       sample_out,
    output logic                          sample_valid_out,
    output logic [CNT_W-1:0]              active_count_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    import synth_pkg::*;

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    sched_state_t            state;
    logic [IDX_W-1:0]        idx;
    logic [NUM_VOICES-1:0]   gate_snap;
    logic [ADDR_W-1:0]       addr_snap [NUM_VOICES];
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    issue_last;
    logic [1:0]              tag_in;
    logic [1:0]              tag_out;

    // Tag = {last lookup of the scan, voice gated}
    assign issue_last = (state == ISSUE) && (idx == LAST_IDX);
    assign tag_in     = {issue_last, (state == ISSUE) && gate_snap[idx]};
    assign busy_out   = (state != IDLE);

    tag_delay_line #(
        .DEPTH (ROM_LATENCY),
        .WIDTH (2)
    ) u_tags (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .tag     (tag_in),
        .delayed (tag_out)
    );

    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        if (tag_out[0]) begin
            acc_next = acc + {{(OUT_W-SAMPLE_W){rom_data_in[SAMPLE_W-1]}},
                              rom_data_in};
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (state == IDLE && sample_tick_in) begin
            gate_snap <= gate_in;
            for (int i = 0; i < NUM_VOICES; i++)
                addr_snap[i] <= phase_value_in[i*PHASE_W + PHASE_W - ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            idx              <= '0;
            acc              <= '0;
            cnt              <= '0;
            rom_addr_out     <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            active_count_out <= '0;
            overrun_out      <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            overrun_out      <= sample_tick_in && (state != IDLE);
            acc              <= acc_next;
            cnt              <= cnt_next;
            unique case (state)
                IDLE: begin
                    if (sample_tick_in) begin
                        state        <= ISSUE;
                        idx          <= '0;
                        acc          <= '0;
                        cnt          <= '0;
                        // Voice 0 address comes straight from the inputs
                        rom_addr_out <= phase_value_in[PHASE_W-1 -: ADDR_W];
                    end
                end
                ISSUE: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX)
                        state <= DRAIN;
                    else
                        rom_addr_out <= addr_snap[idx + 1'b1];
                end
                DRAIN: begin
                    if (tag_out[1]) begin
                        sample_out       <= acc_next;
                        active_count_out <= cnt_next;
                        sample_valid_out <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Randomised bench for voice_mix_scheduler with a behavioural
// ROM and mix reference model.
module tb_voice_mix_scheduler;

    localparam int NV = 24;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic [NV-1:0]   gate = '0;
    logic [NV*PW-1:0] phase = '0;
    logic [7:0]      rom_addr;
    logic [7:0]      rom_data = '0;
    logic [12:0]     sample;
    logic            valid;
    logic [4:0]      active;
    logic            busy;
    logic            overrun;

    always #5 clk = ~clk;

    voice_mix_scheduler dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .sample_tick_in   (tick),
        .gate_in          (gate),
        .phase_value_in   (phase),
        .rom_addr_out     (rom_addr),
        .rom_data_in      (rom_data),
        .sample_out       (sample),
        .sample_valid_out (valid),
        .active_count_out (active),
        .busy_out         (busy),
        .overrun_out      (overrun)
    );

    int  rom_mode = 0;
    byte rom_tab [256];
    int  n_checks = 0;
    int  n_pass = 0;

    function automatic int rom_val(input int mode, input logic [7:0] a);
        case (mode)
            0:       return int'(a) - 128;
            1:       return 127;
            2:       return -128;
            default: return int'(rom_tab[a]);
        endcase
    endfunction

    // Two-cycle synchronous ROM
    logic [7:0] hist0 = '0;
    always @(posedge clk) begin
        hist0    <= rom_addr;
        rom_data <= 8'(rom_val(rom_mode, hist0));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [NV*PW-1:0] rand_phases();
        logic [NV*PW-1:0] p;
        for (int i = 0; i < NV; i++)
            p[i*PW +: PW] = $urandom;
        return p;
    endfunction

    task automatic run_scan(input logic [NV-1:0] g, input logic [NV*PW-1:0] ph,
                            input int mode, input bit toggle, input bit extra);
        int exp_sum = 0;
        int exp_cnt = 0;
        int nvalid = 0;
        int vcycle = -1;
        int nover = 0;
        logic [7:0] a;
        for (int i = 0; i < NV; i++) begin
            a = ph[i*PW + PW - 8 +: 8];
            if (g[i]) begin
                exp_sum += rom_val(mode, a);
                exp_cnt++;
            end
        end
        @(negedge clk);
        rom_mode = mode;
        gate     = g;
        phase    = ph;
        tick     = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 28; c++) begin
            if (c == 1) tick = 1'b0;
            if (toggle && c == 3) begin
                gate  = ~g;
                phase = rand_phases();
            end
            if (extra && c == 10) tick = 1'b1;
            if (extra && c == 11) tick = 1'b0;
            if (c <= NV)
                check("addr", int'(rom_addr), int'(ph[(c-1)*PW + PW - 8 +: 8]));
            check("busy", int'(busy), int'(c <= 27));
            if (valid) begin
                nvalid++;
                vcycle = c;
            end
            if (overrun) nover++;
            if (c < 28) begin
                @(posedge clk);
                #1;
            end
        end
        check("valid_count", nvalid, 1);
        check("valid_cycle", vcycle, 27);
        check("sample", int'($signed(sample)), exp_sum);
        check("active", int'(active), exp_cnt);
        check("overrun", nover, extra ? 1 : 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr"}, int'(rom_addr), 0);
        check({tag, "_sample"}, int'(sample), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        logic [NV*PW-1:0] ph;
        int nvalid;
        for (int i = 0; i < 256; i++)
            rom_tab[i] = byte'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        ph = rand_phases();
        ph[5*PW +: PW] = 32'h4000_0000;
        run_scan(NV'(1) << 5, ph, 0, 1'b0, 1'b0);

        run_scan('0, rand_phases(), 3, 1'b0, 1'b0);
        run_scan('1, rand_phases(), 1, 1'b0, 1'b0);
        run_scan('1, rand_phases(), 2, 1'b0, 1'b0);
        run_scan(NV'($urandom), rand_phases(), 3, 1'b0, 1'b1);
        run_scan(NV'($urandom), rand_phases(), 3, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            run_scan(NV'($urandom), rand_phases(), 3,
                     1'($urandom), 1'($urandom));

        // Async reset in the middle of a scan
        @(negedge clk);
        rom_mode = 1;
        gate     = '1;
        phase    = rand_phases();
        tick     = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (valid) nvalid++;
        end
        check("post_reset_valid", nvalid, 0);
        check("post_reset_busy", int'(busy), 0);

        run_scan(NV'($urandom), rand_phases(), 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/voice_mix_scheduler.md
# voice_mix_scheduler

Time-multiplexes one shared single-port waveform ROM across all voices of the phase accumulator. On each sample tick it snapshots every voice's gate and phase, then issues one ROM lookup per voice, one per cycle. It sums the signed samples of the gated voices into a single mixed sample for the audio output stage. It replaces per-voice ROM copies with one ROM plus a sequencer.

## Interface
Parameters:
- NUM_VOICES, 24, number of voices scanned per sample
- PHASE_W, 32, phase word width
- ADDR_W, 8, ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
- SAMPLE_W, 8, signed ROM sample width
- ROM_LATENCY, 2, cycles from rom_addr_out to valid rom_data_in (≥1)

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- sample_tick_in  in  1  one-cycle strobe requesting a new mixed sample
- gate_in  in  NUM_VOICES  per-voice note-on
- phase_value_in  in  NUM_VOICES×PHASE_W  per-voice accumulated phase
- rom_addr_out  out  ADDR_W  shared ROM address
- rom_data_in  in  SAMPLE_W  signed ROM sample
- sample_out  out  OUT_W (= SAMPLE_W + $clog2(NUM_VOICES)) signed mixed sample
- sample_valid_out  out  1  one-cycle pulse, sample_out updated
- active_count_out  out  $clog2(NUM_VOICES+1)  gated voices in the last mix
- busy_out  out  1  high outside IDLE
- overrun_out  out  1  one-cycle pulse, tick dropped

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on sample_tick_in, register the gate_in and phase_value_in snapshot, clear the accumulator, clear voice_idx, go to ISSUE.
- ISSUE: drive rom_addr_out from snapshot phase[voice_idx] and push gate[voice_idx] into a ROM_LATENCY-deep tag pipeline. Increment voice_idx. After voice NUM_VOICES-1, go to DRAIN.
- DRAIN: wait until the final tag exits the pipeline (ROM_LATENCY cycles), then go to DONE.
- Every cycle a tag exits with gate=1, add sign-extended rom_data_in to the accumulator and increment the active counter. Tags with gate=0 contribute 0.
- DONE: load sample_out and active_count_out, pulse sample_valid_out, return to IDLE.
- Width: accumulator is OUT_W wide and cannot overflow (24×−128 = −3072 fits 13 bits), so no saturation.
- rom_addr_out in IDLE/DRAIN/DONE holds its last value. Its value there is don't-care.
- sample_tick_in while not in IDLE (including DONE): ignore it, pulse overrun_out, and leave the scan in progress undisturbed.
- Gate or phase changes mid-scan have no effect. Only the snapshot is used.
- Reset (async assert, any state): state IDLE, rom_addr_out 0, sample_out 0, sample_valid_out 0, active_count_out 0, busy_out 0, overrun_out 0, tag pipeline cleared. Any partial mix is discarded.

## Timing
- Tick sampled high at edge 0. rom_addr_out for voice i is valid in cycle 1+i.
- Data for voice i is consumed in cycle 1+i+ROM_LATENCY.
- sample_valid_out is high in cycle NUM_VOICES+ROM_LATENCY+1 (27 at defaults). busy_out is high in cycles 1..27.
- Next tick is accepted from cycle 28 onward. Minimum tick period is NUM_VOICES+ROM_LATENCY+2 cycles.
- sample_out and active_count_out hold between valid pulses.

## Structure
- Shared package synth_pkg: NUM_VOICES, PHASE_W, SAMPLE_W, OUT_W localparams, and the scheduler state enum typedef (shared with future arbiters).
- Sub-module tag_delay_line: parameterised depth/width shift register carrying the gate tag alongside the ROM latency. Async active-low reset to 0.

## Test plan
- Reset: assert rst_n_in mid-ISSUE. All outputs go to 0 immediately. After release, no sample_valid_out appears without a new tick.
- Single voice: gate_in=1<<5, phase[5]=32'h4000_0000, ROM model returns addr−128. Expect rom_addr_out=8'h40 in cycle 6, sample_out=−64 and active_count_out=1 in cycle 27.
- All gates off, tick. Expect sample_valid_out in cycle 27 with sample_out=0 and active_count_out=0.
- All 24 gated:
  - ROM returns +127. Expect sample_out=3048, active_count_out=24.
  - ROM returns −128. Expect sample_out=−3072 with no wrap.
- Tick at cycle 10 of a scan. Expect overrun_out pulse, exactly one sample_valid_out at cycle 27, busy_out low at 28.
- Toggle gate_in and phase during a scan. Expect the result to match the snapshot taken at the tick.
